// File: rtl/idi_pkg.sv
// Shared IDI constants and the request bundle carried from client to sink.
package idi_pkg;

    localparam int IDI_ADDR_W = 64;
    localparam int IDI_DATA_W = 32;

    typedef struct packed {
        logic                  is_write;
        logic [IDI_ADDR_W-1:0] addr;
        logic [IDI_DATA_W-1:0] wdata;
    } idi_req_t;

endpackage

// File: rtl/idi_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, registered occupancy.
module idi_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push, pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full blocks the push even when a pop happens in the same cycle.
    assign push = push_i && !full_o;
    assign pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/idi_req_queue.sv
// Client-side request queue feeding the IDI sink, with in-order read responses.
// Define IDI_REQ_QUEUE_STATS_EN to add handshake counters and a level high-water mark.
module idi_req_queue
    import idi_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = IDI_ADDR_W,
    parameter int DATA_W = IDI_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       idi_valid,
    input  logic                       idi_ready,
    output logic                       idi_is_write,
    output logic [ADDR_W-1:0]          idi_addr,
    output logic [DATA_W-1:0]          idi_wdata,
    input  logic [DATA_W-1:0]          idi_rdata,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef IDI_REQ_QUEUE_STATS_EN
   ,output logic [31:0]                stat_wr_cnt,
    output logic [31:0]                stat_rd_cnt,
    output logic [$clog2(DEPTH+1)-1:0] stat_max_level
`endif
);

    localparam int LVL_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t        in_req, head;
    logic        full, empty;
    logic        idi_hs, rd_hs;
    logic        rd_pend_q;
    logic        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign in_req = '{is_write: req_is_write, addr: req_addr, wdata: req_wdata};

    // Ready is forced low while reset is held, independent of the FIFO state.
    assign req_ready = rst_n && !full;

    idi_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid && req_ready),
        .wdata_i (in_req),
        .pop_i   (idi_ready),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign idi_valid    = !empty;
    assign idi_is_write = head.is_write;
    assign idi_addr     = head.addr;
    assign idi_wdata    = head.wdata;

    assign idi_hs = idi_valid && idi_ready;
    assign rd_hs  = idi_hs && !head.is_write;

    // Sink returns data one cycle after the handshake; register it one more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rd_pend_q   <= rd_hs;
            rsp_valid_q <= rd_pend_q;
            if (rd_pend_q) rsp_rdata_q <= idi_rdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef IDI_REQ_QUEUE_STATS_EN
    logic [31:0]      wr_cnt_q, rd_cnt_q;
    logic [LVL_W-1:0] max_lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            max_lvl_q <= '0;
        end else begin
            if (idi_hs && head.is_write) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_hs)                   rd_cnt_q <= rd_cnt_q + 32'd1;
            if (level > max_lvl_q)       max_lvl_q <= level;
        end
    end

    assign stat_wr_cnt    = wr_cnt_q;
    assign stat_rd_cnt    = rd_cnt_q;
    assign stat_max_level = max_lvl_q;
`endif

endmodule

// File: tb/tb_idi_req_queue.sv
// Scoreboard bench for idi_req_queue: driver queues expectations, monitor checks.
module tb_idi_req_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 32;
    localparam int LW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_is_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          idi_valid;
    logic          idi_ready = 1'b0;
    logic          idi_is_write;
    logic [AW-1:0] idi_addr;
    logic [DW-1:0] idi_wdata;
    logic [DW-1:0] idi_rdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [LW-1:0] level;
`ifdef IDI_REQ_QUEUE_STATS_EN
    logic [31:0]   stat_wr_cnt;
    logic [31:0]   stat_rd_cnt;
    logic [LW-1:0] stat_max_level;
`endif

    idi_req_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_write (req_is_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .idi_valid    (idi_valid),
        .idi_ready    (idi_ready),
        .idi_is_write (idi_is_write),
        .idi_addr     (idi_addr),
        .idi_wdata    (idi_wdata),
        .idi_rdata    (idi_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .level        (level)
`ifdef IDI_REQ_QUEUE_STATS_EN
       ,.stat_wr_cnt    (stat_wr_cnt),
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_max_level (stat_max_level)
`endif
    );

    always #5 clk = ~clk;

    exp_t          exp_idi[$];
    logic [DW-1:0] exp_rsp[$];
    int            rd_hs[$];
    logic [DW-1:0] rmem[logic [AW-1:0]];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    exp_t          mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Sink model: read data appears the cycle after a read handshake.
    always @(posedge clk) begin
        if (rst_n && idi_valid && idi_ready && !idi_is_write)
            idi_rdata <= rmem.exists(idi_addr) ? rmem[idi_addr] : 32'hBAD0_BAD0;
        else
            idi_rdata <= 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (idi_valid && idi_ready) begin
                if (exp_idi.size() == 0) begin
                    flag("idi_unexpected");
                end else begin
                    mon_e = exp_idi.pop_front();
                    chk("idi_is_write", 64'(idi_is_write), 64'(mon_e.w));
                    chk("idi_addr", idi_addr, mon_e.a);
                    chk("idi_wdata", 64'(idi_wdata), 64'(mon_e.d));
                    if (!mon_e.w) rd_hs.push_back(cyc);
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0 || rd_hs.size() == 0) begin
                    flag("rsp_unexpected");
                end else begin
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp.pop_front()));
                    chk("rsp_latency", 64'(cyc - rd_hs.pop_front()), 64'(2));
                end
            end
        end
    end

    task automatic drive(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic acc,
                         output logic vld, output logic [LW-1:0] lvl);
        req_valid    = 1'b1;
        req_is_write = w;
        req_addr     = a;
        req_wdata    = d;
        @(negedge clk);
        acc = req_ready;
        vld = idi_valid;
        lvl = level;
        if (acc) begin
            exp_idi.push_back('{w: w, a: a, d: d});
            if (!w) exp_rsp.push_back(rmem[a]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_idi.size() != 0 || exp_rsp.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(exp_idi.size() + exp_rsp.size()), 64'(0));
    endtask

    logic          acc, vld;
    logic [LW-1:0] lvl;

    initial begin
        rmem[64'h2000] = 32'h1234_5678;
        rmem[64'h0200] = 32'h1111_1111;
        rmem[64'h0208] = 32'h2222_2222;
        rmem[64'h0210] = 32'h3333_3333;
        rmem[64'h0400] = 32'h4444_4444;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_idi_valid", 64'(idi_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'(1));
        chk("idle_idi_valid", 64'(idi_valid), 64'(0));
        chk("idle_level", 64'(level), 64'(0));
        @(posedge clk);
        #1;

        // single write
        idi_ready = 1'b1;
        drive(1'b1, 64'h1000, 32'hDEAD_BEEF, acc, vld, lvl);
        chk("wr_accept", 64'(acc), 64'(1));
        chk("wr_no_bypass", 64'(vld), 64'(0));
        @(negedge clk);
        chk("wr_idi_valid", 64'(idi_valid), 64'(1));
        chk("wr_level", 64'(level), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wr_popped_valid", 64'(idi_valid), 64'(0));
        chk("wr_popped_level", 64'(level), 64'(0));
        @(posedge clk);
        #1;
        wait_drain("wr_drain");

        // single read
        drive(1'b0, 64'h2000, 32'h0, acc, vld, lvl);
        chk("rd_accept", 64'(acc), 64'(1));
        wait_drain("rd_drain");

        // fill and backpressure
        idi_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(i * 8), 32'(32'hA0 + i), acc, vld, lvl);
            chk($sformatf("fill_acc%0d", i), 64'(acc), 64'(i < 4));
        end
        @(negedge clk);
        chk("fill_level", 64'(level), 64'(4));
        chk("fill_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 idi_ready = 1'b1;
        wait_drain("fill_drain");
        @(negedge clk);
        chk("fill_level_empty", 64'(level), 64'(0));
        @(posedge clk);
        #1;

        // streaming with three back-to-back reads
        drive(1'b1, 64'h100, 32'h0000_0001, acc, vld, lvl);
        drive(1'b0, 64'h200, 32'h0, acc, vld, lvl);
        chk("stream_level1", 64'(lvl), 64'(1));
        drive(1'b0, 64'h208, 32'h0, acc, vld, lvl);
        chk("stream_level2", 64'(lvl), 64'(1));
        drive(1'b0, 64'h210, 32'h0, acc, vld, lvl);
        chk("stream_level3", 64'(lvl), 64'(1));
        drive(1'b1, 64'h300, 32'h0000_0005, acc, vld, lvl);
        chk("stream_level4", 64'(lvl), 64'(1));
        chk("stream_acc", 64'(acc), 64'(1));
        wait_drain("stream_drain");

`ifdef IDI_REQ_QUEUE_STATS_EN
        chk("stat_wr_cnt", 64'(stat_wr_cnt), 64'(7));
        chk("stat_rd_cnt", 64'(stat_rd_cnt), 64'(4));
        chk("stat_max_level", 64'(stat_max_level), 64'(4));
`endif

        // reset with entries queued and a read in flight
        idi_ready = 1'b0;
        drive(1'b0, 64'h400, 32'h0, acc, vld, lvl);
        drive(1'b1, 64'h408, 32'h0000_0408, acc, vld, lvl);
        drive(1'b1, 64'h410, 32'h0000_0410, acc, vld, lvl);
        drive(1'b1, 64'h418, 32'h0000_0418, acc, vld, lvl);
        idi_ready = 1'b1;
        @(negedge clk);
        chk("mf_level_pre", 64'(level), 64'(4));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idi_ready = 1'b0;
        exp_idi.delete();
        exp_rsp.delete();
        rd_hs.delete();
        @(negedge clk);
        chk("mf_level", 64'(level), 64'(0));
        chk("mf_idi_valid", 64'(idi_valid), 64'(0));
        chk("mf_req_ready", 64'(req_ready), 64'(0));
        chk("mf_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idi_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mf_no_rsp", 64'(rsp_valid), 64'(0));
        end
        chk("mf_level_post", 64'(level), 64'(0));
        chk("mf_idi_valid_post", 64'(idi_valid), 64'(0));
        chk("mf_req_ready_post", 64'(req_ready), 64'(1));
`ifdef IDI_REQ_QUEUE_STATS_EN
        chk("mf_stat_wr", 64'(stat_wr_cnt), 64'(0));
        chk("mf_stat_rd", 64'(stat_rd_cnt), 64'(0));
        chk("mf_stat_max", 64'(stat_max_level), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idi_req_queue.md
Name: idi_req_queue

Overview:
- Upstream feeder for the IDI sink.
- Accepts read/write requests from a client, buffers them in a DEPTH-entry FIFO, and presents them one at a time on the IDI valid/ready port.
- Captures read data returned by the sink and delivers it to the client as a one-cycle response pulse, in request order.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
ADDR_W, 64, IDI address width
DATA_W, 32, IDI data width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  client request valid
req_ready  output  1  queue can accept (not full)
req_is_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data (ignored for reads)
idi_valid  output  1  request presented to sink
idi_ready  input  1  sink accepts
idi_is_write  output  1  head entry type
idi_addr  output  ADDR_W  head entry address
idi_wdata  output  DATA_W  head entry write data
idi_rdata  input  DATA_W  sink read data, valid the cycle after a read handshake
rsp_valid  output  1  one-cycle read-response pulse
rsp_rdata  output  DATA_W  read data for rsp_valid
level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, wr/rd pointers 0, level=0, req_ready=0 while rst_n low, idi_valid=0, rsp_valid=0, rsp_rdata=0, rd_pend=0, stats counters 0.
- Push: req_valid && req_ready at a clock edge writes {is_write, addr, wdata} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- req_ready = !full (combinational from level), held 0 during reset. When full there is no push, even if a pop occurs in the same cycle.
- Pop: idi_valid = !empty. idi_* fields are driven combinationally from the head entry. idi_valid && idi_ready pops; rd_ptr wraps.
- Once asserted, idi_valid and idi_* fields stay stable until the handshake.
- Simultaneous push and pop: level unchanged, both pointers advance.
- No bypass: minimum latency from client push to idi_valid is 1 cycle. An entry pushed into an empty queue appears the next cycle.
- Read tracking, pipelined with no stall:
  - Read handshake in cycle N sets rd_pend on the edge ending N.
  - In cycle N+1, idi_rdata is sampled at the edge: rsp_rdata <= idi_rdata, rsp_valid <= 1.
  - rsp_valid is high in cycle N+2 only; rsp_valid = rd_pend delayed by 1.
  - Back-to-back reads give back-to-back rsp pulses.
  - Writes produce no response.
- No response backpressure: the client must always accept rsp_valid.
- Reset mid-operation: all queued entries and any pending read response are discarded; no rsp_valid after reset release.
- level is a registered count, updated +1 on push, -1 on pop, unchanged on both or neither.

Optional Feature:
- Macro IDI_REQ_QUEUE_STATS_EN.
- When defined, adds output ports stat_wr_cnt[31:0], stat_rd_cnt[31:0] and stat_max_level[$clog2(DEPTH+1)-1:0].
  - Counts are per IDI handshake and wrap modulo 2^32.
  - stat_max_level is a high-water mark of level.
  - All are cleared by rst_n.
- When undefined, these ports and registers are absent and functional behaviour is identical.

Decomposition:
- Package idi_pkg:
  - constants IDI_ADDR_W=64, IDI_DATA_W=32;
  - typedef struct packed idi_req_t {is_write, addr, wdata}.
- One natural sub-module: idi_sync_fifo (parameterised on DEPTH and element type width), holding storage, pointers, level, full/empty.
- idi_req_queue wraps the FIFO and adds the read-response pipeline and the optional stats.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> req_ready=1, idi_valid=0, level=0, rsp_valid never asserts.
- Single write: push write addr=0x1000 wdata=0xDEADBEEF, idi_ready=1 -> idi_valid one cycle after push with same fields; pop next edge; no rsp_valid.
- Single read with sink model (rdata=0x12345678 the cycle after handshake): push read addr=0x2000 -> rsp_valid exactly 2 cycles after the IDI handshake, rsp_rdata=0x12345678.
- Fill and backpressure: idi_ready=0, push 5 requests -> first 4 accepted, level=4, req_ready=0 on the 5th. Raise idi_ready -> drained in push order, addresses 0x0,0x8,0x10,0x18.
- Streaming: push/pop every cycle with 3 consecutive reads -> 3 consecutive rsp_valid pulses, level stays 1, pointers wrap past DEPTH-1 correctly.
- Reset mid-flight: 3 entries queued plus a read handshake done, assert rst_n -> level=0, idi_valid=0, no rsp_valid after release. With IDI_REQ_QUEUE_STATS_EN, stat counters read 0.
